// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues credit-limited imem requests,
// and buffers in-order responses with their PCs for decode.
module fetch_unit #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     FQ_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall_d,
  output logic            valid_d,
  output logic [31:0]     instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d
);

  localparam int unsigned PTR_W = $clog2(FQ_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic [XLEN-1:0]  r_pc;
  logic             r_run;

  logic [31:0]      r_fq_instr [FQ_DEPTH];
  logic [XLEN-1:0]  r_fq_pc    [FQ_DEPTH];
  logic [PTR_W-1:0] r_fq_rd;
  logic [PTR_W-1:0] r_fq_wr;
  logic [CNT_W-1:0] r_fq_cnt;

  logic [XLEN-1:0]  r_pf_pc [FQ_DEPTH];
  logic [PTR_W-1:0] r_pf_rd;
  logic [PTR_W-1:0] r_pf_wr;
  logic [CNT_W-1:0] r_inflight;
  logic [CNT_W-1:0] r_drop;

  logic [SUM_W-1:0] w_credit_used;
  logic             w_req_fire;
  logic             w_rsp_keep;
  logic             w_pop;
  logic [CNT_W-1:0] w_inflight_nxt;

  // Queued entries plus outstanding requests never exceed the queue depth.
  assign w_credit_used  = SUM_W'(r_fq_cnt) + SUM_W'(r_inflight);
  assign imem_req_valid = r_run && !redirect_valid && (w_credit_used < SUM_W'(FQ_DEPTH));
  assign imem_req_addr  = r_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign w_rsp_keep     = imem_rsp_valid && (r_drop == '0) && !redirect_valid;
  assign w_inflight_nxt = r_inflight + CNT_W'(w_req_fire) - CNT_W'(imem_rsp_valid);

  assign valid_d    = (r_fq_cnt != '0);
  assign instr_d    = r_fq_instr[r_fq_rd];
  assign pc_d       = r_fq_pc[r_fq_rd];
  assign pc_plus4_d = pc_d + XLEN'(4);
  assign w_pop      = valid_d && !stall_d && !redirect_valid;

  // PC register and fetch enable after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc  <= RESET_PC;
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (redirect_valid) begin
        r_pc <= redirect_pc & ~XLEN'(3);
      end else if (w_req_fire) begin
        r_pc <= r_pc + XLEN'(4);
      end
    end
  end

  // In-flight PC FIFO plus outstanding/wrong-path counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FQ_DEPTH; i++) begin
        r_pf_pc[i] <= '0;
      end
      r_pf_rd    <= '0;
      r_pf_wr    <= '0;
      r_inflight <= '0;
      r_drop     <= '0;
    end else begin
      if (w_req_fire) begin
        r_pf_pc[r_pf_wr] <= r_pc;
        r_pf_wr          <= r_pf_wr + PTR_W'(1);
      end
      if (imem_rsp_valid) begin
        r_pf_rd <= r_pf_rd + PTR_W'(1);
      end
      r_inflight <= w_inflight_nxt;
      // Everything still outstanding after a redirect edge is wrong-path.
      if (redirect_valid) begin
        r_drop <= w_inflight_nxt;
      end else if (imem_rsp_valid && (r_drop != '0)) begin
        r_drop <= r_drop - CNT_W'(1);
      end
    end
  end

  // Fetch queue feeding decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FQ_DEPTH; i++) begin
        r_fq_instr[i] <= NOP;
        r_fq_pc[i]    <= RESET_PC;
      end
      r_fq_rd  <= '0;
      r_fq_wr  <= '0;
      r_fq_cnt <= '0;
    end else if (redirect_valid) begin
      r_fq_rd  <= '0;
      r_fq_wr  <= '0;
      r_fq_cnt <= '0;
    end else begin
      if (w_rsp_keep) begin
        r_fq_instr[r_fq_wr] <= imem_rsp_data;
        r_fq_pc[r_fq_wr]    <= r_pf_pc[r_pf_rd];
        r_fq_wr             <= r_fq_wr + PTR_W'(1);
      end
      if (w_pop) begin
        r_fq_rd <= r_fq_rd + PTR_W'(1);
      end
      r_fq_cnt <= r_fq_cnt + CNT_W'(w_rsp_keep) - CNT_W'(w_pop);
    end
  end

  a_rsp_needs_inflight: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (r_inflight != '0));

  a_drop_le_inflight: assert property (@(posedge clk) disable iff (!rst_n)
    r_drop <= r_inflight);

endmodule
